// File: rtl/md5_msg_pad.sv
// MD5 message padder: packs 32-bit words into 512-bit blocks, appends 0x80, zero fill and 64-bit bit length.
// Latency: 2 cycles from last-word accept to blk_valid_o; backpressure: input stalls while a block waits.
// Build option MD5_BYTE_SWAP_EN: byte-reverse input words (big-endian input).
module md5_msg_pad #(
  parameter int n     = 32,
  parameter int LEN_W = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [n-1:0] in_data_i,
  input  logic         in_last_i,
  input  logic [1:0]   in_bytes_i,
  output logic [n-1:0] M_o [0:15],
  output logic         blk_valid_o,
  input  logic         blk_ready_i,
  output logic         blk_last_o
);

  typedef enum logic [1:0] {S_FILL, S_PAD, S_EMIT, S_XTRA} state_t;

  state_t           state;
  logic [3:0]       wcnt;
  logic [LEN_W-1:0] len;
  logic [63:0]      len64;
  logic [4:0]       mark_pos;
  logic             need_xtra;
  logic             mark_pending;

  logic [n-1:0]     word_in;
  logic [n-1:0]     last_word;
  logic [2:0]       nbytes;
  logic             accept;

  assign in_ready_o = (state == S_FILL) && !rst_i;
  assign accept     = in_valid_i && in_ready_o;
  assign len64      = 64'(len);

  always_comb begin
`ifdef MD5_BYTE_SWAP_EN
    word_in = {in_data_i[7:0], in_data_i[15:8], in_data_i[23:16], in_data_i[31:24]};
`else
    word_in = in_data_i;
`endif
    nbytes = (in_bytes_i == 2'd0) ? 3'd4 : {1'b0, in_bytes_i};
    // Unused upper bytes are dropped and the 0x80 marker sits right after the last valid byte.
    case (in_bytes_i)
      2'd1:    last_word = {16'h0000, 8'h80, word_in[7:0]};
      2'd2:    last_word = {8'h00, 8'h80, word_in[15:0]};
      2'd3:    last_word = {8'h80, word_in[23:0]};
      default: last_word = word_in;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= S_FILL;
      wcnt         <= 4'd0;
      len          <= '0;
      mark_pos     <= 5'd0;
      need_xtra    <= 1'b0;
      mark_pending <= 1'b0;
      blk_valid_o  <= 1'b0;
      blk_last_o   <= 1'b0;
      for (int i = 0; i < 16; i++) M_o[i] <= '0;
    end else begin
      case (state)
        S_FILL: begin
          if (accept) begin
            wcnt <= wcnt + 4'd1;
            if (in_last_i) begin
              M_o[wcnt] <= last_word;
              len       <= len + LEN_W'({nbytes, 3'b000});
              if (in_bytes_i == 2'd0) begin
                // Full last word: marker opens the next word, or the extra block if none is left.
                mark_pos <= {1'b0, wcnt} + 5'd1;
                if (wcnt != 4'hf) M_o[wcnt + 4'd1] <= 32'h0000_0080;
              end else begin
                mark_pos <= {1'b0, wcnt};
              end
              mark_pending <= (in_bytes_i == 2'd0) && (wcnt == 4'hf);
              state        <= S_PAD;
            end else begin
              M_o[wcnt] <= word_in;
              len       <= len + LEN_W'(32);
              if (wcnt == 4'hf) begin
                blk_valid_o <= 1'b1;
                blk_last_o  <= 1'b0;
                state       <= S_EMIT;
              end
            end
          end
        end

        S_PAD: begin
          for (int i = 0; i < 16; i++) begin
            if (5'(i) > mark_pos) M_o[i] <= '0;
          end
          if (mark_pos <= 5'd13) begin
            M_o[14]    <= len64[31:0];
            M_o[15]    <= len64[63:32];
            blk_last_o <= 1'b1;
            need_xtra  <= 1'b0;
          end else begin
            blk_last_o <= 1'b0;
            need_xtra  <= 1'b1;
          end
          blk_valid_o <= 1'b1;
          state       <= S_EMIT;
        end

        S_EMIT: begin
          if (blk_ready_i) begin
            blk_valid_o <= 1'b0;
            if (need_xtra) begin
              state <= S_XTRA;
            end else begin
              state <= S_FILL;
              wcnt  <= 4'd0;
              if (blk_last_o) len <= '0;
            end
          end
        end

        S_XTRA: begin
          for (int i = 0; i < 16; i++) M_o[i] <= '0;
          if (mark_pending) M_o[0] <= 32'h0000_0080;
          M_o[14]      <= len64[31:0];
          M_o[15]      <= len64[63:32];
          blk_last_o   <= 1'b1;
          blk_valid_o  <= 1'b1;
          need_xtra    <= 1'b0;
          mark_pending <= 1'b0;
          state        <= S_EMIT;
        end

        default: state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_msg_pad.sv
// Bench for md5_msg_pad: fixed and random messages checked against a byte-level MD5 padding model.
module tb_md5_msg_pad;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_data_i;
  logic        in_last_i;
  logic [1:0]  in_bytes_i;
  logic [31:0] M_o [0:15];
  logic        blk_valid_o;
  logic        blk_ready_i;
  logic        blk_last_o;

  int passed = 0;
  int total  = 0;

  logic [7:0]  msg_q[$];
  logic [31:0] exp_q[$];

  md5_msg_pad #(.n(32), .LEN_W(64)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_last_i   (in_last_i),
    .in_bytes_i  (in_bytes_i),
    .M_o         (M_o),
    .blk_valid_o (blk_valid_o),
    .blk_ready_i (blk_ready_i),
    .blk_last_o  (blk_last_o)
  );

  always #5 clk = ~clk;

  task automatic make_msg(input int nbytes);
    msg_q.delete();
    for (int i = 0; i < nbytes; i++) msg_q.push_back(8'($urandom));
  endtask

  // Reference: message bytes, 0x80, zeros to 56 mod 64, 8-byte little-endian bit length.
  task automatic model();
    logic [7:0]  pad[$];
    logic [63:0] bitlen;
    pad = msg_q;
    pad.push_back(8'h80);
    while (pad.size() % 64 != 56) pad.push_back(8'h00);
    bitlen = 64'(msg_q.size()) * 64'd8;
    for (int i = 0; i < 8; i++) pad.push_back(bitlen[8*i +: 8]);
    exp_q.delete();
    for (int k = 0; k < pad.size() / 4; k++)
      exp_q.push_back({pad[4*k+3], pad[4*k+2], pad[4*k+1], pad[4*k]});
  endtask

  task automatic run_msg(input string name);
    int          nw, nblk, widx, bidx, cyc, badi, idx;
    logic [31:0] w;
    logic        acc, take, bad;
    nw   = (msg_q.size() + 3) / 4;
    nblk = exp_q.size() / 16;
    widx = 0; bidx = 0; cyc = 0;
    while ((widx < nw || bidx < nblk) && cyc < 3000) begin
      in_valid_i  = 1'b0;
      blk_ready_i = 1'b0;
      in_last_i   = 1'b0;
      in_data_i   = $urandom;
      in_bytes_i  = 2'($urandom);
      acc = 1'b0; take = 1'b0;
      if (blk_valid_o) begin
        total++;
        if (bidx >= nblk) begin
          $display("FAIL %s extra_block: blk_valid_o=1 after %0d blocks, required 0", name, nblk);
        end else begin
          bad = 1'b0; badi = 0;
          for (int i = 15; i >= 0; i--)
            if (M_o[i] !== exp_q[16*bidx+i]) begin bad = 1'b1; badi = i; end
          if (bad)
            $display("FAIL %s blk%0d word%0d: got %h, required %h", name, bidx, badi,
                     M_o[badi], exp_q[16*bidx+badi]);
          else passed++;
          total++;
          if (blk_last_o !== (bidx == nblk - 1))
            $display("FAIL %s blk%0d last: got %b, required %b", name, bidx, blk_last_o, bidx == nblk - 1);
          else passed++;
        end
        total++;
        if (in_ready_o !== 1'b0)
          $display("FAIL %s ready_during_emit: got %b, required 0", name, in_ready_o);
        else passed++;
        if ($urandom_range(0, 3) != 0) begin blk_ready_i = 1'b1; take = 1'b1; end
      end else if (widx < nw && in_ready_o && $urandom_range(0, 3) != 0) begin
        for (int j = 0; j < 4; j++) begin
          idx = 4*widx + j;
          w[8*j +: 8] = (idx < msg_q.size()) ? msg_q[idx] : 8'($urandom);
        end
        in_valid_i = 1'b1;
        in_data_i  = w;
        if (widx == nw - 1) begin
          in_last_i  = 1'b1;
          in_bytes_i = 2'(msg_q.size() % 4);
        end
        acc = 1'b1;
      end
      @(posedge clk); #1;
      if (acc)  widx++;
      if (take) bidx++;
      cyc++;
    end
    in_valid_i  = 1'b0;
    blk_ready_i = 1'b0;
    in_last_i   = 1'b0;
    total++;
    if (widx != nw || bidx != nblk)
      $display("FAIL %s timeout: words %0d/%0d blocks %0d/%0d, required all", name, widx, nw, bidx, nblk);
    else passed++;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (blk_valid_o !== 1'b0 || in_ready_o !== 1'b1)
      $display("FAIL %s idle_after: valid=%b ready=%b, required 0/1", name, blk_valid_o, in_ready_o);
    else passed++;
  endtask

  task automatic send_abc();
    in_valid_i = 1'b1;
    in_data_i  = 32'hA5636261;
    in_last_i  = 1'b1;
    in_bytes_i = 2'd3;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; in_last_i = 1'b0;
    in_bytes_i = 2'd0; blk_ready_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    total++;
    if (blk_valid_o !== 1'b0 || blk_last_o !== 1'b0 || in_ready_o !== 1'b0)
      $display("FAIL reset_ctrl: valid=%b last=%b ready=%b, required 0/0/0", blk_valid_o, blk_last_o, in_ready_o);
    else passed++;
    total++;
    if (M_o[0] !== 32'h0 || M_o[7] !== 32'h0 || M_o[15] !== 32'h0)
      $display("FAIL reset_M: M0=%h M7=%h M15=%h, required 0", M_o[0], M_o[7], M_o[15]);
    else passed++;
    @(posedge clk); @(posedge clk); #1;
    rst_i = 1'b0;
    #1;
    total++;
    if (in_ready_o !== 1'b1) $display("FAIL reset_release_ready: got %b, required 1", in_ready_o);
    else passed++;
  endtask

  task automatic test_abc();
    logic bad;
    total++;
    if (in_ready_o !== 1'b1) $display("FAIL abc_pre_ready: got %b, required 1", in_ready_o);
    else passed++;
    send_abc();
    total++;
    if (blk_valid_o !== 1'b0 || in_ready_o !== 1'b0)
      $display("FAIL abc_pad_cycle: valid=%b ready=%b, required 0/0", blk_valid_o, in_ready_o);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (blk_valid_o !== 1'b1 || blk_last_o !== 1'b1)
      $display("FAIL abc_latency: valid=%b last=%b, required 1/1", blk_valid_o, blk_last_o);
    else passed++;
    total++;
    if (M_o[0] !== 32'h80636261) $display("FAIL abc_M0: got %h, required 80636261", M_o[0]);
    else passed++;
    total++;
    if (M_o[14] !== 32'h18 || M_o[15] !== 32'h0)
      $display("FAIL abc_len: M14=%h M15=%h, required 00000018/00000000", M_o[14], M_o[15]);
    else passed++;
    bad = 1'b0;
    for (int i = 1; i <= 13; i++) if (M_o[i] !== 32'h0) bad = 1'b1;
    total++;
    if (bad) $display("FAIL abc_zero_fill: M1..M13 got nonzero (M1=%h), required 0", M_o[1]);
    else passed++;
    blk_ready_i = 1'b1;
    @(posedge clk); #1;
    blk_ready_i = 1'b0;
    total++;
    if (blk_valid_o !== 1'b0 || in_ready_o !== 1'b1)
      $display("FAIL abc_handshake: valid=%b ready=%b, required 0/1", blk_valid_o, in_ready_o);
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [31:0] snap [0:15];
    logic        bad;
    blk_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    blk_ready_i = 1'b0;
    total++;
    if (blk_valid_o !== 1'b0 || in_ready_o !== 1'b1)
      $display("FAIL bp_stray_ready: valid=%b ready=%b, required 0/1", blk_valid_o, in_ready_o);
    else passed++;
    send_abc();
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) snap[i] = M_o[i];
    total++;
    if (snap[0] !== 32'h80636261) $display("FAIL bp_M0: got %h, required 80636261", snap[0]);
    else passed++;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      bad = 1'b0;
      for (int i = 0; i < 16; i++) if (M_o[i] !== snap[i]) bad = 1'b1;
      total++;
      if (bad || blk_valid_o !== 1'b1 || in_ready_o !== 1'b0 || blk_last_o !== 1'b1)
        $display("FAIL bp_hold%0d: valid=%b ready=%b last=%b stable=%b, required 1/0/1/1",
                 c, blk_valid_o, in_ready_o, blk_last_o, !bad);
      else passed++;
    end
    blk_ready_i = 1'b1;
    @(posedge clk); #1;
    blk_ready_i = 1'b0;
    total++;
    if (blk_valid_o !== 1'b0 || in_ready_o !== 1'b1)
      $display("FAIL bp_release: valid=%b ready=%b, required 0/1", blk_valid_o, in_ready_o);
    else passed++;
  endtask

  task automatic test_boundaries();
    int lens[10] = '{3, 52, 55, 56, 57, 60, 63, 64, 120, 128};
    foreach (lens[k]) begin
      make_msg(lens[k]);
      model();
      run_msg($sformatf("len%0d", lens[k]));
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    for (int k = 0; k < 7; k++) begin
      in_valid_i = 1'b1;
      in_data_i  = $urandom;
      in_last_i  = 1'b0;
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    total++;
    if (blk_valid_o !== 1'b0 || in_ready_o !== 1'b0 || M_o[0] !== 32'h0)
      $display("FAIL rst_mid_msg: valid=%b ready=%b M0=%h, required 0/0/0", blk_valid_o, in_ready_o, M_o[0]);
    else passed++;
    @(posedge clk); #1;
    rst_i = 1'b0;
    send_abc();
    cyc = 0;
    while (blk_valid_o !== 1'b1 && cyc < 10) begin @(posedge clk); #1; cyc++; end
    total++;
    if (blk_valid_o !== 1'b1) $display("FAIL rst_emit_setup: valid=%b, required 1", blk_valid_o);
    else passed++;
    rst_i = 1'b1;
    #1;
    total++;
    if (blk_valid_o !== 1'b0 || blk_last_o !== 1'b0)
      $display("FAIL rst_mid_emit: valid=%b last=%b, required 0/0", blk_valid_o, blk_last_o);
    else passed++;
    @(posedge clk); #1;
    rst_i = 1'b0;
    msg_q.delete();
    msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
    model();
    run_msg("abc_after_reset");
  endtask

  task automatic test_random();
    for (int m = 0; m < 25; m++) begin
      make_msg($urandom_range(1, 200));
      model();
      run_msg($sformatf("rand%0d", m));
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_backpressure();
    test_boundaries();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
